// File: rtl/host_link_controller_pkg.sv
// Shared definitions for the host-side BIP link controller: state encodings,
// BIP command bytes and default widths.
package host_link_controller_pkg;

  localparam int unsigned CC_LENGTH_DEF      = 11;
  localparam int unsigned ACC_LENGTH_DEF     = 16;
  localparam int unsigned WORD_LENGTH_DEF    = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;
  localparam int unsigned TIMEOUT_LENGTH_DEF = 21;

  // Command bytes understood by the BIP-side responder
  localparam int unsigned BIP_RESET_CMD = 1;
  localparam int unsigned BIP_START_CMD = 2;

  // Opcode the BIP program ends on; the responder reports CC/ACC when it hits it
  localparam logic [4:0] BIP_HALT_OPCODE = 5'b00000;

  localparam int unsigned STATE_W = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = 8'b0000_0001,
    S_SEND_RESET = 8'b0000_0010,
    S_SEND_START = 8'b0000_0100,
    S_WAIT_CC_L  = 8'b0000_1000,
    S_WAIT_CC_H  = 8'b0001_0000,
    S_WAIT_ACC_L = 8'b0010_0000,
    S_WAIT_ACC_H = 8'b0100_0000,
    S_DONE       = 8'b1000_0000
  } state_e;

  localparam logic [STATE_W-1:0] WAIT_MASK = 8'b0111_1000;

  // True in any state that is waiting for a result byte from the responder
  function automatic logic is_wait_state(input state_e s);
    return |(s & WAIT_MASK);
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector: compares the input against its value one clock earlier.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/host_link_controller.sv
// Host-side link controller: sends reset/start commands to the BIP over a UART,
// then collects the four-byte cycle-count/accumulator result with a timeout.
module host_link_controller
  import host_link_controller_pkg::*;
#(
  parameter int unsigned CC_LENGTH      = CC_LENGTH_DEF,
  parameter int unsigned ACC_LENGTH     = ACC_LENGTH_DEF,
  parameter int unsigned WORD_LENGTH    = WORD_LENGTH_DEF,
  parameter int unsigned RESET_CMD      = BIP_RESET_CMD,
  parameter int unsigned START_CMD      = BIP_START_CMD,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_LENGTH = TIMEOUT_LENGTH_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_tx_done,
  input  logic                   i_rx_done,
  input  logic [WORD_LENGTH-1:0] i_data_rx,
  output logic                   o_tx_start,
  output logic [WORD_LENGTH-1:0] o_data_tx,
  output logic                   o_busy,
  output logic                   o_result_valid,
  output logic [CC_LENGTH-1:0]   o_CC,
  output logic [ACC_LENGTH-1:0]  o_ACC,
  output logic                   o_error
);

  localparam int unsigned CC_HI_W  = CC_LENGTH - WORD_LENGTH;
  localparam int unsigned ACC_HI_W = ACC_LENGTH - WORD_LENGTH;
  localparam logic [TIMEOUT_LENGTH-1:0] TIMEOUT_LAST = TIMEOUT_LENGTH'(TIMEOUT_CYCLES - 1);

  state_e state, state_next;

  logic tx_rise_c, rx_rise_c;
  logic in_wait_c, expire_c;

  logic [TIMEOUT_LENGTH-1:0] timeout_cnt, timeout_cnt_d;
  logic                      tx_start_d;
  logic [WORD_LENGTH-1:0]    data_tx_d;
  logic                      busy_d, result_valid_d, error_d;
  logic [CC_LENGTH-1:0]      cc_d;
  logic [ACC_LENGTH-1:0]     acc_d;

  rise_edge_detect u_tx_edge (
    .clk    (i_clock),
    .rst_n  (i_reset),
    .sig    (i_tx_done),
    .rise_c (tx_rise_c)
  );

  rise_edge_detect u_rx_edge (
    .clk    (i_clock),
    .rst_n  (i_reset),
    .sig    (i_rx_done),
    .rise_c (rx_rise_c)
  );

  // A byte arriving in the expiry cycle takes priority over the timeout
  assign in_wait_c = is_wait_state(state);
  assign expire_c  = in_wait_c && !rx_rise_c && (timeout_cnt == TIMEOUT_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (i_run)     state_next = S_SEND_RESET;
      S_SEND_RESET: if (tx_rise_c) state_next = S_SEND_START;
      S_SEND_START: if (tx_rise_c) state_next = S_WAIT_CC_L;
      S_WAIT_CC_L: begin
        if (rx_rise_c)     state_next = S_WAIT_CC_H;
        else if (expire_c) state_next = S_IDLE;
      end
      S_WAIT_CC_H: begin
        if (rx_rise_c)     state_next = S_WAIT_ACC_L;
        else if (expire_c) state_next = S_IDLE;
      end
      S_WAIT_ACC_L: begin
        if (rx_rise_c)     state_next = S_WAIT_ACC_H;
        else if (expire_c) state_next = S_IDLE;
      end
      S_WAIT_ACC_H: begin
        if (rx_rise_c)     state_next = S_DONE;
        else if (expire_c) state_next = S_IDLE;
      end
      S_DONE:              state_next = S_IDLE;
      default:             state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; each transition updates them at the
  // same edge the state changes, so o_tx_start is high in the first cycle of a SEND state
  always_comb begin
    tx_start_d     = 1'b0;
    data_tx_d      = o_data_tx;
    busy_d         = o_busy;
    result_valid_d = o_result_valid;
    error_d        = o_error;
    cc_d           = o_CC;
    acc_d          = o_ACC;
    timeout_cnt_d  = '0;
    case (state)
      S_IDLE: begin
        if (i_run) begin
          tx_start_d     = 1'b1;
          data_tx_d      = WORD_LENGTH'(RESET_CMD);
          busy_d         = 1'b1;
          result_valid_d = 1'b0;
          error_d        = 1'b0;
          cc_d           = '0;
          acc_d          = '0;
        end
      end
      S_SEND_RESET: begin
        if (tx_rise_c) begin
          tx_start_d = 1'b1;
          data_tx_d  = WORD_LENGTH'(START_CMD);
        end
      end
      S_WAIT_CC_L, S_WAIT_CC_H, S_WAIT_ACC_L, S_WAIT_ACC_H: begin
        if (rx_rise_c) begin
          case (state)
            S_WAIT_CC_L:  cc_d[WORD_LENGTH-1:0]          = i_data_rx;
            S_WAIT_CC_H:  cc_d[CC_LENGTH-1:WORD_LENGTH]  = i_data_rx[CC_HI_W-1:0];
            S_WAIT_ACC_L: acc_d[WORD_LENGTH-1:0]         = i_data_rx;
            default: begin
              acc_d[ACC_LENGTH-1:WORD_LENGTH] = i_data_rx[ACC_HI_W-1:0];
              result_valid_d                  = 1'b1;
              busy_d                          = 1'b0;
            end
          endcase
        end else if (expire_c) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          timeout_cnt_d = timeout_cnt + TIMEOUT_LENGTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_tx_start     <= 1'b0;
      o_data_tx      <= '0;
      o_busy         <= 1'b0;
      o_result_valid <= 1'b0;
      o_CC           <= '0;
      o_ACC          <= '0;
      o_error        <= 1'b0;
      timeout_cnt    <= '0;
    end else begin
      o_tx_start     <= tx_start_d;
      o_data_tx      <= data_tx_d;
      o_busy         <= busy_d;
      o_result_valid <= result_valid_d;
      o_CC           <= cc_d;
      o_ACC          <= acc_d;
      o_error        <= error_d;
      timeout_cnt    <= timeout_cnt_d;
    end
  end

endmodule

// File: tb/tb_host_link_controller.sv
// Directed bench for host_link_controller: table of result transactions plus
// hand-written timeout, robustness and reset sequences.
module tb_host_link_controller;

  localparam int unsigned TO = 40;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_run = 1'b0;
  logic        i_tx_done = 1'b0;
  logic        i_rx_done = 1'b0;
  logic [7:0]  i_data_rx = 8'h00;
  logic        o_tx_start;
  logic [7:0]  o_data_tx;
  logic        o_busy;
  logic        o_result_valid;
  logic [10:0] o_CC;
  logic [15:0] o_ACC;
  logic        o_error;

  int n_checks = 0;
  int n_errors = 0;

  host_link_controller #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_LENGTH (21)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_run          (i_run),
    .i_tx_done      (i_tx_done),
    .i_rx_done      (i_rx_done),
    .i_data_rx      (i_data_rx),
    .o_tx_start     (o_tx_start),
    .o_data_tx      (o_data_tx),
    .o_busy         (o_busy),
    .o_result_valid (o_result_valid),
    .o_CC           (o_CC),
    .o_ACC          (o_ACC),
    .o_error        (o_error)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [7:0]  cc_l;
    logic [7:0]  cc_h;
    logic [7:0]  acc_l;
    logic [7:0]  acc_h;
    logic [10:0] cc;
    logic [15:0] acc;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tx_start"}, 32'(o_tx_start), 0);
    check({name, "_data_tx"},  32'(o_data_tx), 0);
    check({name, "_busy"},     32'(o_busy), 0);
    check({name, "_valid"},    32'(o_result_valid), 0);
    check({name, "_cc"},       32'(o_CC), 0);
    check({name, "_acc"},      32'(o_ACC), 0);
    check({name, "_error"},    32'(o_error), 0);
  endtask

  task automatic start_run();
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
    check("run_busy", 32'(o_busy), 1);
    check("run_valid_cleared", 32'(o_result_valid), 0);
    check("run_error_cleared", 32'(o_error), 0);
  endtask

  task automatic wait_tx(input logic [7:0] exp);
    int n = 0;
    while (o_tx_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("tx_start_seen", 32'(o_tx_start), 1);
    check("tx_byte", 32'(o_data_tx), 32'(exp));
    tick();
    check("tx_start_one_cycle", 32'(o_tx_start), 0);
    check("tx_byte_stable", 32'(o_data_tx), 32'(exp));
  endtask

  task automatic ack_tx();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    i_data_rx = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    tick();
  endtask

  task automatic send_cmds();
    start_run();
    wait_tx(8'h01);
    ack_tx();
    wait_tx(8'h02);
    ack_tx();
  endtask

  initial begin
    logic saw_pulse;

    vecs[0] = '{8'h2A, 8'h05, 8'h34, 8'h12, 11'h52A, 16'h1234};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'h00, 11'h700, 16'h0000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 11'h7FF, 16'hFFFF};
    vecs[3] = '{8'h01, 8'h08, 8'hAB, 8'hCD, 11'h001, 16'hCDAB};
    vecs[4] = '{8'h10, 8'h03, 8'h00, 8'h80, 11'h310, 16'h8000};

    tick();
    tick();
    check_all_zero("reset");
    i_reset = 1'b1;
    tick();

    // Table of complete transactions
    for (int i = 0; i < 5; i++) begin
      send_cmds();
      rx_byte(vecs[i].cc_l);
      rx_byte(vecs[i].cc_h);
      rx_byte(vecs[i].acc_l);
      check("mid_busy", 32'(o_busy), 1);
      check("mid_valid", 32'(o_result_valid), 0);
      rx_byte(vecs[i].acc_h);
      check("res_cc", 32'(o_CC), 32'(vecs[i].cc));
      check("res_cc_hi_bits", 32'(o_CC[10:8]), 32'(vecs[i].cc[10:8]));
      check("res_acc", 32'(o_ACC), 32'(vecs[i].acc));
      check("res_valid", 32'(o_result_valid), 1);
      check("res_busy", 32'(o_busy), 0);
      check("res_error", 32'(o_error), 0);
      tick();
    end

    // Timeout after two result bytes
    send_cmds();
    rx_byte(8'h11);
    rx_byte(8'h02);
    repeat (TO - 2) tick();
    check("to_pre_error", 32'(o_error), 0);
    check("to_pre_busy", 32'(o_busy), 1);
    tick();
    check("to_error", 32'(o_error), 1);
    check("to_busy", 32'(o_busy), 0);
    check("to_valid", 32'(o_result_valid), 0);
    tick();

    // Last byte lands in the expiry cycle
    send_cmds();
    rx_byte(8'h2A);
    rx_byte(8'h05);
    rx_byte(8'h34);
    repeat (TO - 2) tick();
    check("exp_pre_error", 32'(o_error), 0);
    check("exp_pre_busy", 32'(o_busy), 1);
    rx_byte(8'h12);
    check("exp_error", 32'(o_error), 0);
    check("exp_valid", 32'(o_result_valid), 1);
    check("exp_acc", 32'(o_ACC), 32'h1234);
    check("exp_busy", 32'(o_busy), 0);
    tick();

    // Robustness: rx during SEND_START, tx_done and run during WAIT states
    start_run();
    wait_tx(8'h01);
    ack_tx();
    wait_tx(8'h02);
    rx_byte(8'hEE);
    check("ss_data_hold", 32'(o_data_tx), 32'h02);
    ack_tx();
    ack_tx();
    tick();
    rx_byte(8'h2A);
    rx_byte(8'h05);
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
    saw_pulse = 1'b0;
    repeat (3) begin
      saw_pulse |= o_tx_start;
      tick();
    end
    check("run_ignored_no_tx", 32'(saw_pulse), 0);
    check("run_ignored_busy", 32'(o_busy), 1);
    rx_byte(8'h34);
    rx_byte(8'h12);
    check("rob_cc", 32'(o_CC), 32'h52A);
    check("rob_acc", 32'(o_ACC), 32'h1234);
    check("rob_valid", 32'(o_result_valid), 1);
    tick();

    // Asynchronous reset during WAIT_CC_H
    send_cmds();
    rx_byte(8'h2A);
    check("pre_rst_cc", 32'(o_CC), 32'h02A);
    #2;
    i_reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    i_reset = 1'b1;
    saw_pulse = 1'b0;
    repeat (5) begin
      tick();
      saw_pulse |= o_tx_start;
    end
    check("post_rst_no_tx", 32'(saw_pulse), 0);
    check("post_rst_busy", 32'(o_busy), 0);
    send_cmds();
    rx_byte(8'h10);
    rx_byte(8'h03);
    rx_byte(8'h00);
    rx_byte(8'h80);
    check("post_rst_cc", 32'(o_CC), 32'h310);
    check("post_rst_acc", 32'(o_ACC), 32'h8000);
    check("post_rst_valid", 32'(o_result_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
